// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator/capture family.
// State encoding, default width and counter limit helper.
package pwm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam int PWM_WIDTH_DEF = 16;

  // Control-register bit positions shared with the generator.
  // Capture polarity occupies the generator's align bit.
  localparam int PWM_CTRL_EN_BIT    = 0;
  localparam int PWM_CTRL_ALIGN_BIT = 1;
  localparam int PWM_CTRL_POL_BIT   = PWM_CTRL_ALIGN_BIT;

  localparam logic PWM_POL_ACT_HIGH = 1'b0;
  localparam logic PWM_POL_ACT_LOW  = 1'b1;

  // Largest value a w-bit saturating counter can hold.
  function automatic longint unsigned pwm_cnt_max(
    input int unsigned w
  );
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Pin synchronizer with polarity and edge detection.
// Outputs the active level plus single-cycle rise/fall.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pol_i,
  input  logic pin_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   raw;
  logic                   prev_s;

  assign raw = sync_q[SYNC_STAGES-1];

  // Shift the pin through the chain; keep the last raw level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= raw;
    end
  end

  // History is kept raw so a polarity change never fakes an edge.
  assign s_o    = raw ^ pol_i;
  assign prev_s = prev_q ^ pol_i;
  assign rise_o = s_o & ~prev_s;
  assign fall_o = ~s_o & prev_s;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / active-time measurement with stuck detection.
// Results are held as status registers until the next update.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             polarity,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX =
    WIDTH'(pwm_cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             sth_q, sth_d;
  logic             stl_q, stl_d;
  logic             pol_q, pol_d;

  logic             s, rise, fall;
  logic             at_max;
  logic [WIDTH-1:0] cnt_inc;
  logic             to_hit, to_high;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .pol_i (pol_q),
    .pin_i (pwm_in),
    .s_o   (s),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign at_max  = (cnt_q == CNT_MAX);
  assign cnt_inc = at_max ? cnt_q : cnt_q + ONE;

  // Next-state: edge-driven measurement, timeout, and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    per_d   = per_q;
    high_d  = high_q;
    valid_d = 1'b0;
    sth_d   = sth_q;
    stl_d   = stl_q;
    pol_d   = pol_q;
    to_hit  = 1'b0;
    to_high = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cap_en) begin
          state_d = ST_ARM;
          pol_d   = polarity;
        end
      end
      ST_ARM: begin
        if (rise) begin
          cnt_d   = ONE;
          state_d = ST_HIGH;
        end else if (at_max) begin
          to_hit  = 1'b1;
          to_high = s;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          hi_d    = cnt_q;
          cnt_d   = cnt_inc;
          state_d = ST_LOW;
        end else if (at_max) begin
          to_hit  = 1'b1;
          to_high = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          per_d   = cnt_q;
          high_d  = hi_q;
          valid_d = 1'b1;
          sth_d   = 1'b0;
          stl_d   = 1'b0;
          cnt_d   = ONE;
          state_d = ST_HIGH;
        end else if (at_max) begin
          to_hit  = 1'b1;
          to_high = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_hit) begin
      valid_d = 1'b1;
      cnt_d   = '0;
      state_d = ST_ARM;
      per_d   = CNT_MAX;
      high_d  = to_high ? CNT_MAX : '0;
      sth_d   = to_high;
      stl_d   = ~to_high;
    end
    if (!cap_en && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      per_d   = per_q;
      high_d  = high_q;
      valid_d = 1'b0;
      sth_d   = sth_q;
      stl_d   = stl_q;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      sth_q   <= 1'b0;
      stl_q   <= 1'b0;
      pol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      sth_q   <= sth_d;
      stl_q   <= stl_d;
      pol_q   <= pol_d;
    end
  end

  assign period_out = per_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign stuck_high = sth_q;
  assign stuck_low  = stl_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: time-stamp model plus directed checks.
// WIDTH=8 so the stuck timeouts are reachable quickly.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int CMAX = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cap_en = 1'b0;
  logic         polarity = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         meas_valid;
  logic         stuck_high;
  logic         stuck_low;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;

  pwm_capture #(
    .WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .polarity  (polarity),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Detected level at an edge = pin value driven three edges earlier.
  // Measurements are derived from edge time stamps.
  int       cyc = 0;
  bit       d1, d2, d3;
  bit       m_on, m_pol;
  int       m_ph;
  int       m_anchor, m_rise;
  int       m_hi;
  bit [W-1:0] e_per, e_hi;
  bit       e_valid, e_sh, e_sl;

  function automatic int clampm(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic m_timeout(input bit hi_lvl);
    e_valid  = 1'b1;
    e_per    = W'(CMAX);
    e_hi     = hi_lvl ? W'(CMAX) : '0;
    e_sh     = hi_lvl;
    e_sl     = ~hi_lvl;
    m_ph     = 0;
    m_anchor = cyc + 1;
  endtask

  initial begin
    bit lvl, prv, rs, fl;
    forever begin
      @(posedge clk);
      cyc++;
      lvl = d2 ^ m_pol;
      prv = d3 ^ m_pol;
      rs  = lvl & ~prv;
      fl  = ~lvl & prv;
      e_valid = 1'b0;
      if (rst) begin
        d1 = 0; d2 = 0; d3 = 0;
        m_on = 0; m_pol = 0;
        e_per = '0; e_hi = '0;
        e_sh = 0; e_sl = 0;
      end else begin
        d3 = d2; d2 = d1; d1 = pwm_in;
        if (!m_on) begin
          if (cap_en) begin
            m_on = 1; m_ph = 0;
            m_anchor = cyc + 1;
            m_pol = polarity;
          end
        end else if (!cap_en) begin
          m_on = 0;
        end else if (m_ph == 0) begin
          if (rs) begin
            m_ph = 1; m_rise = cyc;
          end else if (cyc - m_anchor >= CMAX) begin
            m_timeout(lvl);
          end
        end else if (m_ph == 1) begin
          if (fl) begin
            m_hi = clampm(cyc - m_rise);
            m_ph = 2;
          end else if (cyc - m_rise >= CMAX) begin
            m_timeout(1'b1);
          end
        end else begin
          if (rs) begin
            e_valid = 1'b1;
            e_per   = W'(clampm(cyc - m_rise));
            e_hi    = W'(m_hi);
            e_sh    = 0; e_sl = 0;
            m_rise  = cyc;
            m_ph    = 1;
          end else if (cyc - m_rise >= CMAX) begin
            m_timeout(1'b0);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (meas_valid === 1'b1) n_valid++;
        check($sformatf("model cyc %0d", cyc),
              {12'd0, period_out, high_out, meas_valid,
               stuck_high, stuck_low, busy},
              {12'd0, e_per, e_hi, e_valid,
               e_sh, e_sl, m_on});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic p);
    @(posedge clk);
    #1 pwm_in = p;
  endtask

  task automatic hold(input logic p, input int n);
    repeat (n) tick(p);
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int i;
    bit found;

    // Reset with a toggling pin.
    for (int k = 0; k < 3; k++) tick(k % 2 == 0);
    check("rst period", period_out, 0);
    check("rst high", high_out, 0);
    check("rst flags",
          {meas_valid, stuck_high, stuck_low, busy}, 0);
    rst = 1'b0; cap_en = 1'b1; pwm_in = 1'b0;
    tick(1'b0);
    check("busy after en", busy, 1);

    // Periodic 3 high / 7 low.
    hold(1'b0, 5);
    nv = n_valid;
    wave(3, 7, 6);
    hold(1'b0, 5);
    check("per count", n_valid - nv, 5);
    check("per period", period_out, 10);
    check("per high", high_out, 3);

    // Inverted; polarity toggled mid-capture has no effect.
    cap_en = 1'b0;
    hold(1'b0, 1);
    polarity = 1'b1; cap_en = 1'b1;
    hold(1'b0, 4);
    nv = n_valid;
    wave(3, 7, 2);
    polarity = 1'b0;
    wave(3, 7, 4);
    hold(1'b0, 5);
    check("inv count", n_valid - nv, 5);
    check("inv period", period_out, 10);
    check("inv high", high_out, 7);

    // Abort mid-HIGH, then re-enable during a partial period.
    cap_en = 1'b0;
    hold(1'b0, 1);
    cap_en = 1'b1;
    hold(1'b0, 4);
    wave(3, 7, 3);
    hold(1'b1, 5);
    nv = n_valid;
    cap_en = 1'b0;
    hold(1'b1, 1);
    check("abort busy", busy, 0);
    hold(1'b1, 3);
    check("abort no valid", n_valid - nv, 0);
    check("abort period", period_out, 10);
    check("abort high", high_out, 3);
    cap_en = 1'b1;
    hold(1'b1, 2);
    hold(1'b0, 4);
    check("partial none", n_valid - nv, 0);
    wave(3, 7, 2);
    hold(1'b0, 5);
    check("reen count", n_valid - nv, 1);
    check("reen period", period_out, 10);
    check("reen high", high_out, 3);

    // Stuck high: timeout 255 cycles after the detected rise.
    @(posedge clk);
    #1 pwm_in = 1'b1;
    i = 0; found = 0;
    while (i < 400 && !found) begin
      @(negedge clk);
      i++;
      if (meas_valid === 1'b1 && stuck_high === 1'b1)
        found = 1;
    end
    check("sh found", found, 1);
    check("sh latency", i, 259);
    check("sh period", period_out, 255);
    check("sh high", high_out, 255);
    check("sh low flag", stuck_low, 0);

    // Resume with 2 high / 3 low.
    hold(1'b1, 1);
    nv = n_valid;
    wave(2, 3, 4);
    hold(1'b0, 5);
    check("res count", n_valid - nv, 2);
    check("res period", period_out, 5);
    check("res high", high_out, 2);
    check("res sh clr", stuck_high, 0);

    // Stuck low.
    i = 0; found = 0;
    while (i < 400 && !found) begin
      @(negedge clk);
      i++;
      if (meas_valid === 1'b1 && stuck_low === 1'b1)
        found = 1;
    end
    check("sl found", found, 1);
    check("sl period", period_out, 255);
    check("sl high", high_out, 0);
    check("sl sh flag", stuck_high, 0);

    // Fastest signal: 1 high / 1 low.
    hold(1'b0, 2);
    nv = n_valid;
    wave(1, 1, 20);
    hold(1'b0, 5);
    check("sq count", n_valid - nv, 19);
    check("sq period", period_out, 2);
    check("sq high", high_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
